// File: rtl/register_file_pkg.sv
// Shared types and helpers for the parametrised register file.
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_REGS   = 32;

  typedef enum logic {
    RF_CLEAR,
    RF_IDLE
  } rf_state_t;

  // An address may be written or read only when it is in range and is not a hardwired x0.
  function automatic logic rf_addr_legal(input int unsigned addr,
                                         input int unsigned num_regs,
                                         input logic        zero_reg);
    return (addr < num_regs) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/register_file_clear_fsm.sv
// Clear-sweep controller: zeroes storage one entry per cycle after reset or on request,
// and holds ready low until the sweep is done.
module register_file_clear_fsm
  import register_file_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  // x0 never needs clearing when it is hardwired, so the sweep starts at 1.
  localparam logic [ADDR_W-1:0] PTR_INIT = ADDR_W'((ZERO_REG != 0) ? 1 : 0);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NUM_REGS - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;

  // Next-state logic: walk the pointer during a sweep, accept a new request only when idle.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    case (state_q)
      RF_CLEAR: begin
        if (clr_ptr_q >= PTR_LAST) begin
          state_d = RF_IDLE;
          ready_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      RF_IDLE: begin
        if (clr_req) begin
          state_d   = RF_CLEAR;
          clr_ptr_d = PTR_INIT;
          ready_d   = 1'b0;
        end
      end
    endcase
  end

  // State registers; reset always lands in a fresh sweep so storage needs no reset of its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= PTR_INIT;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  assign clr_we   = (state_q == RF_CLEAR);
  assign clr_addr = clr_ptr_q;
  assign ready    = ready_q;

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file with multiple asynchronous read ports and a clear sweep.
// Optional macro REGISTER_FILE_BYPASS_EN forwards same-cycle write data to matching reads.
module register_file_param
  import register_file_pkg::*;
#(
  parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter  int NUM_REGS     = DEFAULT_NUM_REGS,
  parameter  int NUM_RD_PORTS = 2,
  parameter  int ZERO_REG     = 1,
  localparam int ADDR_W       = $clog2(NUM_REGS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic [ADDR_W-1:0]                      wr_reg,
  input  logic [DATA_WIDTH-1:0]                  wr_data,
  input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]    rd_reg,
  output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data,
  input  logic                                   clr_req,
  output logic                                   ready
);

  logic                  clr_we;
  logic [ADDR_W-1:0]     clr_addr;
  logic                  wr_legal;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  register_file_clear_fsm #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  assign wr_legal = rf_addr_legal(32'(wr_reg), NUM_REGS, ZERO_REG != 0);

  // Write mux: the sweep owns the write port while it runs; otherwise legal user writes pass.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wr_reg;
    mem_wdata = wr_data;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end else if (wr_en && ready && wr_legal) begin
      mem_we = 1'b1;
    end
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  // Read ports: gated to zero while sweeping, for x0 and for out-of-range addresses.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (ready && rf_addr_legal(32'(rd_reg[p]), NUM_REGS, ZERO_REG != 0)) begin
        rd_data[p] = mem_q[rd_reg[p]];
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_en && wr_legal && (wr_reg == rd_reg[p])) begin
          rd_data[p] = wr_data;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param: a default instance (32 regs, 2 ports, x0
// hardwired) and a small instance (20 regs, 3 ports, x0 writable) share the write/clear inputs.
module tb_register_file_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             wr_en;
  logic             clr_req;
  logic [4:0]       wr_reg;
  logic [31:0]      wr_data;
  logic [1:0][4:0]  rd_a;
  logic [2:0][4:0]  rd_b;
  logic [1:0][31:0] rdata_a;
  logic [2:0][31:0] rdata_b;
  logic             ready_a;
  logic             ready_b;

  register_file_param #(
    .DATA_WIDTH(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .ZERO_REG(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg(rd_a), .rd_data(rdata_a), .clr_req(clr_req), .ready(ready_a)
  );

  register_file_param #(
    .DATA_WIDTH(32), .NUM_REGS(20), .NUM_RD_PORTS(3), .ZERO_REG(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg(rd_b), .rd_data(rdata_b), .clr_req(clr_req), .ready(ready_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register contents plus the number of edges left before ready returns.
  logic [31:0] mdl [2][32];
  int          busy [2];
  int          nregs [2] = '{32, 20};
  int          zr [2]    = '{1, 0};

  function automatic bit legal(input int d, input logic [4:0] a);
    return (int'(a) < nregs[d]) && !(zr[d] == 1 && a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input int d, input logic [4:0] a);
    if (busy[d] != 0) return 32'h0;
    if (!legal(d, a)) return 32'h0;
`ifdef REGISTER_FILE_BYPASS_EN
    if (wr_en && legal(d, wr_reg) && wr_reg == a) return wr_data;
`endif
    return mdl[d][a];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) busy[d] = nregs[d] - zr[d];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " ready_a"}, 32'(ready_a), 32'(busy[0] == 0));
    checkOutput({tag, " ready_b"}, 32'(ready_b), 32'(busy[1] == 0));
    for (int p = 0; p < 2; p++)
      checkOutput($sformatf("%s a.rd%0d(x%0d)", tag, p, rd_a[p]), rdata_a[p], exp_rd(0, rd_a[p]));
    for (int p = 0; p < 3; p++)
      checkOutput($sformatf("%s b.rd%0d(x%0d)", tag, p, rd_b[p]), rdata_b[p], exp_rd(1, rd_b[p]));
  endtask

  task automatic applyStimulus(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                               input bit cr);
    wr_en   = we;
    wr_reg  = wr;
    wr_data = wd;
    clr_req = cr;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic tick(input string tag);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        busy[d] = nregs[d] - zr[d];
      end else if (busy[d] > 0) begin
        busy[d]--;
        if (busy[d] == 0)
          for (int i = 0; i < 32; i++) mdl[d][i] = 32'h0;
      end else begin
        if (wr_en && legal(d, wr_reg)) mdl[d][wr_reg] = wr_data;
        if (clr_req) busy[d] = nregs[d] - zr[d];
      end
    end
    #1;
    checkModel(tag);
  endtask

  task automatic waitReady(input string tag, input int exp_edges);
    int n = 0;
    while (!ready_a && n < 100) begin
      tick(tag);
      n++;
    end
    checkOutput({tag, " edges until ready"}, 32'(n), 32'(exp_edges));
  endtask

  typedef struct {
    bit          we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] same_exp;

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd3,  5'd4,  32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd1,  5'd2,  32'h0,        32'h0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[5] = '{1'b1, 5'd31, 32'h00000001, 5'd30, 5'd5,  32'h0,        32'hDEADBEEF};
    vecs[6] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd31, 5'd6,  32'h1,        32'h0};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hCAFEF00D, 32'h1};

    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    rd_a = '0;
    rd_b = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) mdl[d][i] = 32'h0;
    model_reset();
    #2;
    checkModel("reset");

    // Release reset between edges and time the power-on sweep.
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitReady("reset sweep", 31);

    for (int a = 1; a < 32; a++) begin
      rd_a[0] = 5'(a);
      rd_a[1] = 5'(a);
      rd_b[0] = 5'(a);
      tick("post-reset read");
      checkOutput($sformatf("post-reset x%0d", a), rdata_a[0], 32'h0);
    end

    // Table-driven write/read vectors against the default instance.
    rd_b = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wr, vecs[i].wd, 1'b0);
      rd_a[0] = vecs[i].r0;
      rd_a[1] = vecs[i].r1;
      #1;
      checkOutput($sformatf("vec%0d rd0", i), rdata_a[0], vecs[i].e0);
      checkOutput($sformatf("vec%0d rd1", i), rdata_a[1], vecs[i].e1);
      tick($sformatf("vec%0d", i));
    end

    // Same-cycle write and read of x7.
`ifdef REGISTER_FILE_BYPASS_EN
    same_exp = 32'h12345678;
`else
    same_exp = 32'h0;
`endif
    applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b0);
    rd_a[0] = 5'd7;
    rd_a[1] = 5'd7;
    #1;
    checkOutput("same-cycle x7 port0", rdata_a[0], same_exp);
    checkOutput("same-cycle x7 port1", rdata_a[1], same_exp);
    tick("same-cycle");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checkOutput("after write x7", rdata_a[0], 32'h12345678);

    // x0 behaviour in both builds and out-of-range handling on the 20-entry instance.
    rd_a[0] = 5'd0;
    rd_b[0] = 5'd0;
    #1;
    checkOutput("a x0 hardwired", rdata_a[0], 32'h0);
    checkOutput("b x0 writable", rdata_b[0], 32'hFFFFFFFF);
    applyStimulus(1'b1, 5'd25, 32'h55AA55AA, 1'b0);
    rd_b[1] = 5'd25;
    rd_a[0] = 5'd3;
    tick("oob write");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    rd_a[0] = 5'd25;
    #1;
    checkOutput("b x25 out of range", rdata_b[1], 32'h0);
    checkOutput("a x25 written", rdata_a[0], 32'h55AA55AA);

    // Fill, then clear on request; a write during the sweep is dropped.
    for (int a = 1; a < 32; a++) begin
      applyStimulus(1'b1, 5'(a), 32'hA5A5A5A5, 1'b0);
      tick("fill");
    end
    applyStimulus(1'b1, 5'd3, 32'h00000077, 1'b1);
    tick("clr_req");
    checkOutput("ready low after clr_req", 32'(ready_a), 32'h0);
    applyStimulus(1'b1, 5'd9, 32'h00000001, 1'b0);
    tick("write during sweep");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    waitReady("clear sweep", 30);
    rd_a[1] = 5'd9;
    for (int a = 1; a < 32; a++) begin
      rd_a[0] = 5'(a);
      rd_b[2] = 5'(a);
      tick("post-clear read");
      checkOutput($sformatf("post-clear x%0d", a), rdata_a[0], 32'h0);
    end
    checkOutput("x9 dropped during sweep", rdata_a[1], 32'h0);

    // Reset in the middle of a sweep restarts a full sweep.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    tick("clr for midreset");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    repeat (10) tick("sweep before reset");
    rst_n = 1'b0;
    model_reset();
    #1;
    checkModel("mid-sweep reset");
    tick("in reset");
    tick("in reset");
    rst_n = 1'b1;
    waitReady("mid-sweep restart", 31);

    // Randomised traffic against the model, with occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    ($urandom_range(0, 39) == 0));
      for (int p = 0; p < 2; p++) rd_a[p] = 5'($urandom_range(0, 31));
      for (int p = 0; p < 3; p++) rd_b[p] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rd_a[1] = wr_reg;
      #1;
      checkModel("rand pre-edge");
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor to the core's 32x32 register file.
- Generalised in data width, register count and number of read ports, with x0 hardwiring selectable.
- Contains a clear-sweep state machine that zeroes storage one entry per cycle after reset or on request. This lets storage map to FPGA distributed RAM, which has no reset.
- Sits in the decode stage; the ready output stalls the pipeline while a sweep is in progress.

Parameters:
- DATA_WIDTH, 32, width of each register.
- NUM_REGS, 32, number of registers; need not be a power of two.
- NUM_RD_PORTS, 2, number of independent asynchronous read ports (1 to 4).
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes.
- Derived: ADDR_W = $clog2(NUM_REGS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write enable.
- wr_reg  in  ADDR_W  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_reg  in  NUM_RD_PORTS x ADDR_W  read address per port.
- rd_data  out  NUM_RD_PORTS x DATA_WIDTH  read data per port; combinational from rd_reg.
- clr_req  in  1  single-cycle request to zero all registers.
- ready  out  1  high when idle; low during a sweep.

Behaviour:
- FSM states are RF_CLEAR and RF_IDLE.
- rst_n low (asynchronous):
  - state goes to RF_CLEAR; clr_ptr = ZERO_REG ? 1 : 0; ready = 0.
  - all rd_data read as 0, because reads are gated while not ready.
  - storage itself is not reset.
- RF_CLEAR:
  - each rising edge writes 0 to mem[clr_ptr], then clr_ptr increments.
  - when clr_ptr == NUM_REGS-1 is written, next state is RF_IDLE.
  - the sweep takes NUM_REGS-ZERO_REG cycles after rst_n deasserts (31 at defaults).
  - ready is registered and rises in the first RF_IDLE cycle.
- RF_CLEAR restrictions:
  - wr_en is ignored.
  - clr_req is ignored; no restart.
  - every rd_data reads 0.
- RF_IDLE:
  - clr_req = 1 moves to RF_CLEAR on the next edge, reloads clr_ptr, and deasserts ready.
  - a user write in the same cycle as clr_req is still committed, then swept.
- Write:
  - mem[wr_reg] <= wr_data on the rising edge when wr_en & ready.
  - the write is dropped if ZERO_REG and wr_reg == 0.
  - the write is dropped if wr_reg >= NUM_REGS.
- Read:
  - rd_data[p] = mem[rd_reg[p]], combinational.
  - reads 0 if ZERO_REG and rd_reg[p] == 0, if rd_reg[p] >= NUM_REGS, or if !ready.
- Same-cycle write and read of the same address: the read returns the old value (write-after-read ordering), unless bypass is enabled.
- Multiple ports reading the same address all return identical data.
- rst_n asserted mid-sweep aborts the sweep; a full sweep restarts from the initial clr_ptr after deassertion.

Optional Feature:
- Macro: REGISTER_FILE_BYPASS_EN.
- When defined, each read port forwards wr_data in place of storage if all of the following hold:
  - wr_en & ready;
  - wr_reg == rd_reg[p];
  - the write is legal (not x0 with ZERO_REG, in range).
  This gives read-during-write semantics for a same-cycle write-back stage.
- When undefined, reads always return stored contents (old value).
- Write behaviour is identical in both builds.

Decomposition:
- Package register_file_pkg:
  - DEFAULT_DATA_WIDTH and DEFAULT_NUM_REGS constants.
  - rf_state_t enum {RF_CLEAR, RF_IDLE}.
  - function rf_addr_legal(addr, num_regs, zero_reg).
- Sub-module register_file_clear_fsm:
  - owns state, clr_ptr and ready.
  - outputs clr_we and clr_addr to the storage write mux.
- The top level holds the storage array, write mux, read gating and bypass.

Test Plan:
- Reset sweep: pulse rst_n low, release -> ready = 0 for exactly 31 cycles, then 1; all rd_data = 0 throughout; reads of x1..x31 after ready = 0x00000000.
- Basic write/read: write x5 = 0xDEADBEEF; next cycle rd_reg = {5,5} -> both ports 0xDEADBEEF; rd_reg = {0,5} -> port0 0, port1 0xDEADBEEF.
- x0 protection: write x0 = 0xFFFFFFFF -> x0 reads 0 on all ports; with ZERO_REG = 0, x0 reads 0xFFFFFFFF.
- Same-cycle write/read: x7 holds 0x0; write x7 = 0x12345678 while reading x7 -> 0x0 without REGISTER_FILE_BYPASS_EN, 0x12345678 with it; next cycle 0x12345678 in both builds.
- Clear request: fill x1..x31 with 0xA5A5A5A5, pulse clr_req -> ready low next cycle; write x9 = 0x1 during the sweep is dropped; after 31 cycles ready = 1 and all registers read 0.
- Mid-sweep reset and parameters: assert rst_n at sweep cycle 10 -> ready stays 0 for a full 31 cycles after release; NUM_REGS = 20, NUM_RD_PORTS = 3: write wr_reg = 25 is dropped and rd_reg = 25 reads 0.
